q_max_argmax_pipe: RTL

Q_MAX_ARGMAX_PIPE -- requirements
Module: q_max_argmax_pipe

---
 rtl/q_max_argmax_pipe_pkg.sv | 44 ++++
 rtl/q_max_argmax_pipe_fp_max_idx_cell.sv | 28 ++
 rtl/q_max_argmax_pipe.sv | 111 +++++++++++
 3 files changed

// File: rtl/q_max_argmax_pipe_pkg.sv
// Shared constants and helpers for the Q-value max/argmax reduction pipeline.
// Holds the binary32 encoding constants and the per-level element counts of the reduction tree.
package q_max_argmax_pipe_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned FP_SIGN_BIT = 31;
  localparam logic [DATA_WIDTH-1:0] FP_POS_ZERO = '0;

  // Element count at a given level of the tree (level 0 is the raw row), rounding up.
  function automatic int unsigned level_count(int unsigned ch, int unsigned lvl);
    return (ch + (32'd1 << lvl) - 32'd1) >> lvl;
  endfunction

  // Start of a level within the flat node array that holds every level back to back.
  function automatic int unsigned level_offset(int unsigned ch, int unsigned lvl);
    int unsigned acc;
    acc = 0;
    for (int unsigned l = 0; l < 5; l++) begin
      if (l < lvl) acc += level_count(ch, l);
    end
    return acc;
  endfunction

  // Stage that writes register slot r, where slots cover levels 1 and up.
  function automatic int unsigned reg_stage(int unsigned ch, int unsigned r);
    int unsigned acc;
    int unsigned lvl;
    acc = 0;
    lvl = 0;
    for (int unsigned l = 0; l < 5; l++) begin
      acc += level_count(ch, l + 1);
      if (r >= acc) lvl = l + 1;
    end
    return lvl;
  endfunction

  // Maps binary32 onto an unsigned key whose integer order is the float order; -0 folds to +0.
  function automatic logic [DATA_WIDTH-1:0] fp_order_key(logic [DATA_WIDTH-1:0] x);
    logic [DATA_WIDTH-1:0] v;
    v = (x[FP_SIGN_BIT-1:0] == '0) ? FP_POS_ZERO : x;
    return v[FP_SIGN_BIT] ? ~v : {1'b1, v[FP_SIGN_BIT-1:0]};
  endfunction

endpackage

// File: rtl/q_max_argmax_pipe_fp_max_idx_cell.sv
// Combinational binary32 max of two (value, index) pairs.
// Equal values (including +0 against -0) resolve to the lower index.
module fp_max_idx_cell
  import q_max_argmax_pipe_pkg::*;
#(
  parameter int unsigned IDX_W = 2
) (
  input  logic [DATA_WIDTH-1:0] a_val_i,
  input  logic [IDX_W-1:0]      a_idx_i,
  input  logic [DATA_WIDTH-1:0] b_val_i,
  input  logic [IDX_W-1:0]      b_idx_i,
  output logic [DATA_WIDTH-1:0] win_val_o,
  output logic [IDX_W-1:0]      win_idx_o
);

  logic [DATA_WIDTH-1:0] key_a;
  logic [DATA_WIDTH-1:0] key_b;
  logic                  b_wins;

  always_comb begin
    key_a     = fp_order_key(a_val_i);
    key_b     = fp_order_key(b_val_i);
    b_wins    = (key_b > key_a) || ((key_b == key_a) && (b_idx_i < a_idx_i));
    win_val_o = b_wins ? b_val_i : a_val_i;
    win_idx_o = b_wins ? b_idx_i : a_idx_i;
  end

endmodule

// File: rtl/q_max_argmax_pipe.sv
// Pipelined max/argmax over a row of binary32 Q-values, one pairwise level per register stage.
// A single stall enable freezes the whole pipe while the output is held.
module q_max_argmax_pipe
  import q_max_argmax_pipe_pkg::*;
#(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned DATA_WIDTH = q_max_argmax_pipe_pkg::DATA_WIDTH,
  localparam int unsigned LEVELS    = $clog2(CHANNELS),
  localparam int unsigned IDX_W     = (LEVELS > 1) ? LEVELS : 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [DATA_WIDTH*CHANNELS-1:0] i_data,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [DATA_WIDTH-1:0]          o_max,
  output logic [IDX_W-1:0]               o_index
);

  localparam int unsigned NODES = level_offset(CHANNELS, LEVELS) + 1;
  localparam int unsigned NREGS = NODES - CHANNELS;

  // Node array: level 0 is the input row, later levels are the stage registers.
  logic [DATA_WIDTH-1:0] node_val [NODES];
  logic [IDX_W-1:0]      node_idx [NODES];
  logic [DATA_WIDTH-1:0] nxt_val  [NREGS];
  logic [IDX_W-1:0]      nxt_idx  [NREGS];
  logic [DATA_WIDTH-1:0] val_q    [NREGS];
  logic [DATA_WIDTH-1:0] val_d    [NREGS];
  logic [IDX_W-1:0]      idx_q    [NREGS];
  logic [IDX_W-1:0]      idx_d    [NREGS];
  logic [LEVELS-1:0]     vld_q;
  logic [LEVELS-1:0]     vld_d;
  logic [LEVELS-1:0]     stage_in;
  logic                  en;

  assign en       = !vld_q[LEVELS-1] || i_ready;
  assign stage_in = LEVELS'({vld_q, i_valid});

  for (genvar k = 0; k < CHANNELS; k++) begin : g_row
    assign node_val[k] = i_data[DATA_WIDTH*k +: DATA_WIDTH];
    assign node_idx[k] = IDX_W'(k);
  end

  for (genvar r = 0; r < NREGS; r++) begin : g_reg_node
    assign node_val[CHANNELS+r] = val_q[r];
    assign node_idx[CHANNELS+r] = idx_q[r];
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int unsigned NIn    = level_count(CHANNELS, l);
    localparam int unsigned NOut   = level_count(CHANNELS, l + 1);
    localparam int unsigned InOff  = level_offset(CHANNELS, l);
    localparam int unsigned OutOff = level_offset(CHANNELS, l + 1) - CHANNELS;
    for (genvar j = 0; j < NOut; j++) begin : g_pair
      if (2 * j + 1 < NIn) begin : g_cmp
        fp_max_idx_cell #(
          .IDX_W(IDX_W)
        ) u_cell (
          .a_val_i  (node_val[InOff+2*j]),
          .a_idx_i  (node_idx[InOff+2*j]),
          .b_val_i  (node_val[InOff+2*j+1]),
          .b_idx_i  (node_idx[InOff+2*j+1]),
          .win_val_o(nxt_val[OutOff+j]),
          .win_idx_o(nxt_idx[OutOff+j])
        );
      end else begin : g_pass
        // Odd leftover rides through this level untouched.
        assign nxt_val[OutOff+j] = node_val[InOff+2*j];
        assign nxt_idx[OutOff+j] = node_idx[InOff+2*j];
      end
    end
  end

  always_comb begin
    vld_d = vld_q;
    val_d = val_q;
    idx_d = idx_q;
    if (en) begin
      vld_d = stage_in;
      for (int unsigned r = 0; r < NREGS; r++) begin
        if (stage_in[reg_stage(CHANNELS, r)]) begin
          val_d[r] = nxt_val[r];
          idx_d[r] = nxt_idx[r];
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_q <= '0;
      for (int unsigned r = 0; r < NREGS; r++) begin
        val_q[r] <= FP_POS_ZERO;
        idx_q[r] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      val_q <= val_d;
      idx_q <= idx_d;
    end
  end

  assign o_ready = en;
  assign o_valid = vld_q[LEVELS-1];
  assign o_max   = val_q[NREGS-1];
  assign o_index = idx_q[NREGS-1];

endmodule
